fpmult_scheduler: RTL

Round-robin scheduler that shares one pipelined floating-point multiplier (unpack → multiply → normalize → round) among NREQ requesters. It accepts at most one operand pair per cycle and carries a requester tag alongside the fixed-latency multiplier pipeline. It routes each rounded product back to the requester that issued it. It sits between the requesting compute units and the single FPMult instance, which it sequences and feeds.

---
 rtl/fpmult_pkg.sv | 19 +
 rtl/fpmult_scheduler_if.sv | 30 +++
 rtl/fpmult_rr_arbiter.sv | 50 +++++
 rtl/fpmult_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fpmult_pkg.sv
// Shared definitions for the FP-multiplier scheduler: operand width, tag stage
// record and the one-hot helper used for grants and result strobes.
package fpmult_pkg;

  localparam int FP_W    = 32;
  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/fpmult_scheduler_if.sv
// Requester-side bus of the FP-multiplier scheduler: packed operand pairs,
// one-hot grant and the routed result.
interface fpmult_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  import fpmult_pkg::*;

  // Handshake: requester i holds req_valid[i] with stable operands; the pair is
  // taken in the cycle where req_valid[i] & req_ready[i]. res_valid has no
  // ready and must be consumed in the cycle it is presented.
  logic [NREQ-1:0]      req_valid;
  logic [FP_W*NREQ-1:0] req_a;
  logic [FP_W*NREQ-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      res_valid;
  logic [FP_W-1:0]      res_z;
  logic [IDW-1:0]       res_id;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_z, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_z, res_id
  );

endinterface

// File: rtl/fpmult_rr_arbiter.sv
// Combinational round-robin grant for the scheduler. With FPMULT_SCHED_PRIO_EN
// defined, requester 0 wins outright and the rest rotate among themselves.
module fpmult_rr_arbiter
  import fpmult_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            halt,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_vld
);

  logic [NREQ-1:0] rr_req;
  logic [NREQ-1:0] rot;
  logic            found;
  logic [ID_W:0]   cand;

  always_comb begin
`ifdef FPMULT_SCHED_PRIO_EN
    rr_req = {req[NREQ-1:1], 1'b0};
`else
    rr_req = req;
`endif
    // Rotate so bit 0 is the requester at ptr; first set bit wins.
    rot       = NREQ'({rr_req, rr_req} >> ptr);
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        cand  = {1'b0, ptr} + (ID_W+1)'(j);
        if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
        grant_idx = cand[ID_W-1:0];
      end
    end
`ifdef FPMULT_SCHED_PRIO_EN
    if (req[0]) begin
      found     = 1'b1;
      grant_idx = '0;
    end
`endif
    grant_vld = found && !halt;
    grant     = grant_vld ? NREQ'(onehot(grant_idx)) : '0;
  end

endmodule

// File: rtl/fpmult_scheduler.sv
// Shares one fixed-latency FP multiplier among NREQ requesters, tagging each
// operation so its product returns to the issuer. Option: FPMULT_SCHED_PRIO_EN.
module fpmult_scheduler
  import fpmult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  fpmult_scheduler_if.slave rq,
  input  logic             halt,
  output logic             mul_valid,
  output logic [FP_W-1:0]  mul_a,
  output logic [FP_W-1:0]  mul_b,
  input  logic [FP_W-1:0]  mul_z,
  output logic [3:0]       inflight,
  output logic             idle
);

  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            accept;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            mul_valid_q, mul_valid_d;
  logic [FP_W-1:0] mul_a_q, mul_a_d;
  logic [FP_W-1:0] mul_b_q, mul_b_d;
  tag_t            tag_q [LAT+1];
  tag_t            tag_d [LAT+1];
  logic [NREQ-1:0] res_valid_q, res_valid_d;
  logic [FP_W-1:0] res_z_q, res_z_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic [3:0]      inflight_q, inflight_d;

  logic [FP_W-1:0] win_a, win_b;
  logic            ret_vld;

  fpmult_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (rq.req_valid),
    .ptr       (ptr_q),
    .halt      (halt),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (accept)
  );

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_a = rq.req_a[FP_W*i +: FP_W];
        win_b = rq.req_b[FP_W*i +: FP_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef FPMULT_SCHED_PRIO_EN
    // Priority grants to requester 0 leave the rotation untouched.
    if (accept && grant_idx != '0)
`else
    if (accept)
`endif
      ptr_d = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    mul_valid_d = accept;
    mul_a_d     = accept ? win_a : mul_a_q;
    mul_b_d     = accept ? win_b : mul_b_q;
  end

  // Tag pipe runs alongside the multiplier; the last stage lines up with mul_z.
  always_comb begin
    tag_d[0] = '{valid: accept, id: grant_idx};
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];
  end

  always_comb begin
    ret_vld     = tag_q[LAT].valid;
    res_valid_d = ret_vld ? NREQ'(onehot(tag_q[LAT].id)) : '0;
    res_z_d     = ret_vld ? mul_z : res_z_q;
    res_id_d    = ret_vld ? IDW'(tag_q[LAT].id) : res_id_q;
    inflight_d  = inflight_q + {3'b000, accept} - {3'b000, ret_vld};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
      res_valid_q <= '0;
      res_z_q     <= '0;
      res_id_q    <= '0;
      inflight_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= tag_d[k];
      res_valid_q <= res_valid_d;
      res_z_q     <= res_z_d;
      res_id_q    <= res_id_d;
      inflight_q  <= inflight_d;
    end
  end

  assign rq.req_ready = grant;
  assign rq.res_valid = res_valid_q;
  assign rq.res_z     = res_z_q;
  assign rq.res_id    = res_id_q;
  assign mul_valid    = mul_valid_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign inflight     = inflight_q;
  assign idle         = (inflight_q == '0) && !accept;

endmodule
